peak_tracker: RTL and testbench
===============================

Name: peak_tracker

Overview:
- Streaming stage that sits directly downstream of the 4-bit magnitude comparator and consumes its gt decision.
- Accepts one 4-bit sample per valid/ready handshake and tracks the running maximum over a fixed window of WIN_LEN samples.
- At window end, reports the maximum and its index through an output valid/ready handshake.
- Feeds display/decision logic downstream.

Parameters:
- DATA_W, 4: sample width; fixed at 4 to match the comparator, and any other value is a compile-time error.
- WIN_LEN, 8: samples per window, legal range 2..256.
- IDX_W, $clog2(WIN_LEN): width of the index/count fields (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort of the current window.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  DATA_W  sample value, unsigned.
- out_valid  output  1  window result available.
- out_ready  input  1  consumer takes the result.
- out_max  output  DATA_W  maximum of the window.
- out_idx  output  IDX_W  position (0-based) of the first occurrence of the maximum.
- out_min  output  DATA_W  minimum of the window (see Optional Feature).
- busy  output  1  high while a window is partially filled or a result is pending.

Behaviour:
- Reset (rst_n low, async): state=ACCUM, count=0, max_r=0, idx_r=0, min_r=0.
- Reset output values: in_ready=1, out_valid=0, out_max=0, out_idx=0, out_min=0, busy=0.
- Accept condition: in_valid && in_ready on a rising clk edge.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On accept with count==0: max_r<=in_data, idx_r<=0.
  - On accept with count!=0: if comparator gt(a=in_data, b=max_r)=1, then max_r<=in_data and idx_r<=count; otherwise hold.
  - Ties are not greater, so the earliest index is kept.
  - Every accept increments count.
  - An accept when count==WIN_LEN-1 moves to REPORT; count wraps to 0.
- REPORT state:
  - in_ready=0, out_valid=1.
  - out_max/out_idx/out_min are driven from the registers and stay stable until the handshake.
  - On out_valid && out_ready, return to ACCUM next cycle.
  - out_valid may stay high indefinitely; no result is ever dropped or overwritten.
- Latency: out_valid rises on the clock edge that accepts the last sample, i.e. visible the cycle after the last in handshake.
- Throughput: minimum WIN_LEN+1 cycles per window (one REPORT cycle with out_ready=1).
- in_ready is a function of state only, with no combinational path from out_ready.
- busy = (count!=0) || (state==REPORT).
- clear:
  - Synchronous and highest priority over every handshake in the same cycle.
  - Forces state=ACCUM and count=0; a sample presented that cycle is discarded.
  - A pending result is dropped (out_valid=0 next cycle).
  - max_r/idx_r/min_r keep their values; they are overwritten by the next first sample.
- Async reset mid-window or mid-REPORT: immediate return to reset values; no partial result is emitted.
- in_valid during REPORT is ignored (in_ready=0); the upstream stage must hold its data.

Optional Feature:
- Macro PEAK_TRACKER_MIN_EN.
- When defined:
  - A second comparator instance evaluates gt(a=min_r, b=in_data).
  - min_r loads on the first sample and on strict-less samples.
  - out_min reports the window minimum under the same timing as out_max.
- When undefined:
  - The second comparator and min_r are not instantiated.
  - out_min is tied to 0.
  - All other behaviour is identical.

Decomposition:
- Shared package peak_pkg holds:
  - localparam CMP_W=4;
  - typedef enum logic {ACCUM, REPORT} peak_state_t;
  - typedef logic [CMP_W-1:0] sample_t.
- Sub-module: the existing 4-bit comparator is instantiated (one instance, or two with PEAK_TRACKER_MIN_EN) for all magnitude decisions; no separate a>b logic is written inside peak_tracker.
- Counter and FSM stay in the top module.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, out_max=0, out_idx=0, busy=0.
- Window 3,9,2,9,1,0,5,7 back-to-back with out_ready=1 -> out_valid for exactly 1 cycle with out_max=9, out_idx=1 (tie keeps first), out_min=0 when MIN_EN is defined.
- Window 15,14,13,12,11,10,9,8 with out_ready=0 for 5 cycles -> out_valid held, out_max=15, out_idx=0, in_ready=0 throughout; a sample offered in that period is not consumed.
- Window 0,0,0,0,0,0,0,15 -> out_max=15, out_idx=7; a following window 4x8 -> out_max=4, out_idx=0 (no carry-over from the previous window).
- Feed 1,2,3, pulse clear together with sample 12, then 5,5,5,5,5,5,5,6 -> out_max=6, out_idx=7; the 12 is never reported.
- Assert rst_n low during REPORT (out_max=9 pending) -> out_valid=0 and out_max=0 immediately (async); after release, the next full window reports correctly.

Source files
------------

// File: rtl/peak_pkg.sv
// Shared types for the peak tracker slice: comparator width, FSM state
// encoding and the sample type.
package peak_pkg;

    localparam int CMP_W = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } peak_state_t;

    typedef logic [CMP_W-1:0] sample_t;

endpackage

// File: rtl/peak_tracker_cmp.sv
// 4-bit unsigned magnitude comparator: gt is high when a is strictly
// greater than b.
module peak_tracker_cmp
    import peak_pkg::*;
(
    input  logic [CMP_W-1:0] a,
    input  logic [CMP_W-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/peak_tracker.sv
// Windowed running-maximum tracker over WIN_LEN samples, reporting max and
// first index per window. Define PEAK_TRACKER_MIN_EN to also track the minimum.
module peak_tracker
    import peak_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int WIN_LEN = 8,
    parameter int IDX_W   = $clog2(WIN_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_min,
    output logic              busy
);

    if (DATA_W != CMP_W) begin : g_bad_width
        $error("peak_tracker: DATA_W must equal the comparator width");
    end
    if ((WIN_LEN < 2) || (WIN_LEN > 256)) begin : g_bad_win
        $error("peak_tracker: WIN_LEN must be within 2..256");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    peak_state_t      state_r;
    logic [IDX_W-1:0] count_r;
    sample_t          max_r;
    logic [IDX_W-1:0] idx_r;
    logic             accept_s;
    logic             first_s;
    logic             gt_max_s;

    assign accept_s = in_valid && (state_r == ACCUM);
    assign first_s  = (count_r == {IDX_W{1'b0}});

    // All magnitude decisions go through the shared comparator block.
    peak_tracker_cmp u_cmp_max (
        .a  (sample_t'(in_data)),
        .b  (max_r),
        .gt (gt_max_s)
    );

    // Window FSM and sample counter; clear outranks every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
            count_r <= {IDX_W{1'b0}};
        end else if (clear) begin
            state_r <= ACCUM;
            count_r <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (count_r == LAST_IDX) begin
                            count_r <= {IDX_W{1'b0}};
                            state_r <= REPORT;
                        end else begin
                            count_r <= count_r + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_r <= ACCUM;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                    count_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Running maximum; ties keep the earlier index since they are not greater.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_r <= {CMP_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (accept_s && !clear) begin
            if (first_s) begin
                max_r <= sample_t'(in_data);
                idx_r <= {IDX_W{1'b0}};
            end else if (gt_max_s) begin
                max_r <= sample_t'(in_data);
                idx_r <= count_r;
            end
        end
    end

`ifdef PEAK_TRACKER_MIN_EN
    sample_t min_r;
    logic    lt_min_s;

    peak_tracker_cmp u_cmp_min (
        .a  (min_r),
        .b  (sample_t'(in_data)),
        .gt (lt_min_s)
    );

    // Running minimum, loaded on the first sample and on strictly smaller ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r <= {CMP_W{1'b0}};
        end else if (accept_s && !clear) begin
            if (first_s || lt_min_s) begin
                min_r <= sample_t'(in_data);
            end
        end
    end

    assign out_min = DATA_W'(min_r);
`else
    assign out_min = {DATA_W{1'b0}};
`endif

    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == REPORT);
    assign out_max   = DATA_W'(max_r);
    assign out_idx   = idx_r;
    assign busy      = (count_r != {IDX_W{1'b0}}) || (state_r == REPORT);

endmodule

// File: tb/tb_peak_tracker.sv
// Directed, table-driven bench for peak_tracker with WIN_LEN=8.
module tb_peak_tracker;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_max;
    logic [2:0] out_idx;
    logic [3:0] out_min;
    logic       busy;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic [31:0] smp;
        logic [3:0]  emax;
        logic [2:0]  eidx;
        logic [3:0]  emin;
    } vec_t;

    vec_t tbl [5];

    peak_tracker #(.DATA_W(4), .WIN_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_min   (out_min),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_min(input int mn);
`ifdef PEAK_TRACKER_MIN_EN
        return mn;
`else
        return 0;
`endif
    endfunction

    // Samples are packed with sample 0 in the most significant nibble.
    task automatic feed_window(input logic [31:0] smp);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = smp[4*(7-i) +: 4];
            chk("in_ready_accum", int'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic check_result(input string tag, input int emax, input int eidx, input int emn);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_max"}, int'(out_max), emax);
        chk({tag, "_idx"}, int'(out_idx), eidx);
        chk({tag, "_min"}, int'(out_min), exp_min(emn));
        chk({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;

        tbl[0] = '{smp: 32'h3929_1057, emax: 4'd9,  eidx: 3'd1, emin: 4'd0};
        tbl[1] = '{smp: 32'h0000_000F, emax: 4'd15, eidx: 3'd7, emin: 4'd0};
        tbl[2] = '{smp: 32'h4444_4444, emax: 4'd4,  eidx: 3'd0, emin: 4'd4};
        tbl[3] = '{smp: 32'h1234_5678, emax: 4'd8,  eidx: 3'd7, emin: 4'd1};
        tbl[4] = '{smp: 32'h5FF0_F321, emax: 4'd15, eidx: 3'd1, emin: 4'd0};

        #12;
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_min", int'(out_min), 0);
        chk("rst_busy", int'(busy), 0);

        // Back-to-back windows with out_ready held high: one REPORT cycle each.
        for (int v = 0; v < 5; v++) begin
            feed_window(tbl[v].smp);
            check_result($sformatf("win%0d", v), int'(tbl[v].emax), int'(tbl[v].eidx), int'(tbl[v].emin));
            chk("win_busy_report", int'(busy), 1);
            tick();
            chk("win_valid_one_cycle", int'(out_valid), 0);
            chk("win_busy_after", int'(busy), 0);
        end

        // Back-pressure: result held for 5 cycles, offered sample not consumed.
        feed_window(32'hFEDC_BA98);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd3;
        for (int c = 0; c < 5; c++) begin
            check_result("hold", 15, 0, 8);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_result("hold_last", 15, 0, 8);
        tick();
        chk("hold_released", int'(out_valid), 0);
        chk("hold_no_consume_busy", int'(busy), 0);
        feed_window(32'h2222_2222);
        check_result("after_hold", 2, 0, 2);
        tick();

        // clear in the same cycle as a sample of 12 discards it and the partial window.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            tick();
        end
        chk("partial_busy", int'(busy), 1);
        in_data = 4'd12;
        clear   = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_in_ready", int'(in_ready), 1);
        chk("clear_out_valid", int'(out_valid), 0);
        feed_window(32'h5555_5556);
        check_result("clear_win", 6, 7, 5);
        tick();

        // clear during a pending result drops it.
        feed_window(32'h1111_1111);
        out_ready = 1'b0;
        chk("clr_rep_pending", int'(out_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_rep_dropped", int'(out_valid), 0);
        chk("clr_rep_busy", int'(busy), 0);
        out_ready = 1'b1;

        // Async reset while a result of 9 is pending.
        feed_window(tbl[0].smp);
        out_ready = 1'b0;
        check_result("pre_reset", 9, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", int'(out_valid), 0);
        chk("areset_out_max", int'(out_max), 0);
        chk("areset_out_idx", int'(out_idx), 0);
        chk("areset_in_ready", int'(in_ready), 1);
        chk("areset_busy", int'(busy), 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_reset_valid", int'(out_valid), 0);
        feed_window(tbl[3].smp);
        check_result("post_reset_win", 8, 7, 1);
        tick();
        chk("post_reset_done", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
